decode_stage: RTL and testbench
===============================

# decode_stage

Buffered, handshaked instruction-decode stage for the RV32 core. It sits between fetch and issue. A parametrised instruction queue absorbs fetch/issue rate mismatch, and each instruction is decoded into a registered output bundle with valid/ready flow control. It adds a pipeline flush, illegal-instruction detection and an optional M-extension decode path.

## Interface
- DEPTH, 4: queue entries; power of 2, ≥2
- PC_W, 32: PC width carried alongside each instruction
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous discard of all buffered and output-held instructions
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts; equals (occupancy < DEPTH) && !flush
- in_instr  in  32  raw instruction word
- in_pc  in  PC_W  PC of in_instr
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  issue consumes bundle
- out_pc  out  PC_W  PC of decoded instruction
- out_rs1, out_rs2, out_rd  out  5 each  register fields, instr[19:15], [24:20], [11:7]
- out_funct7  out  7  instr[31:25]
- out_funct3  out  3  instr[14:12]
- out_opcode  out  7  instr[6:0]
- out_imm  out  32  sign-extended immediate
- out_instr_type  out  3  INSTR_TYPE_* class
- out_illegal  out  1  instruction not decodable
- occupancy  out  $clog2(DEPTH)+1  entries currently held in the queue; the output register is not counted

## Operation
- Push: in_valid && in_ready at an edge writes {in_instr, in_pc} to the queue tail.
- in_ready does not look at the same-cycle pop. When the queue is full, in_ready is 0 even if a pop occurs.
- Output register load: when the queue is non-empty and (!out_valid || out_ready), the head is popped, decoded and registered. out_valid is then 1.
- If the queue is empty and out_ready is high, out_valid falls at the next edge.
- Push and pop in the same cycle: occupancy is unchanged. Pointers wrap modulo DEPTH.
- Immediate selection:
  - I-format for LOAD and ALU_IMM
  - S-format for STORE
  - B-format for BRANCH
  - U-format ({instr[31:12], 12'b0}) for AUIPC and LUI
  - J-format for all other opcodes
- Instruction class:
  - MUL: OPCODE_ALU with funct7 = MUL_FUNCT7
  - ALU: other OPCODE_ALU, AUIPC, ALU_IMM, NOP
  - LOAD: LOAD, LUI
  - STORE: STORE
  - NO_WB: everything else
- Illegal detection. out_illegal = 1 when any of the following holds:
  - instr[1:0] ≠ 2'b11
  - the opcode is not in the OPCODE_* set
  - OPCODE_ALU with funct7 ∉ {7'h00, 7'h20, MUL_FUNCT7}
- An illegal instruction forces out_instr_type = NO_WB. All field outputs still reflect the raw word.
- Flush, while high at an edge:
  - the queue empties: occupancy → 0, pointers → 0
  - out_valid → 0
  - in_ready is 0 for the whole cycle, so no push occurs
  - flush has priority over push, pop and load
- Reset (rst_n low, asynchronous):
  - out_valid, occupancy, pointers and every out_* field → 0
  - in_ready → 1 after reset deasserts
- Hold: while out_valid && !out_ready, every out_* output is stable.

## Timing
- Latency: an instruction pushed at edge N appears with out_valid = 1 after edge N+1. There is no bypass.
- Sustained throughput is 1 instruction/cycle when in_valid and out_ready are both held high.
- Total capacity is DEPTH + 1 instructions (the queue plus the output register).
- in_ready and occupancy are derived from registered state plus flush only. There is no combinational path from out_ready to in_ready.
- Decode logic sits between the queue head and the output register. It must close within a single cycle.

## Configuration
- RV32M_DECODE_EN defined: funct7 = MUL_FUNCT7 on OPCODE_ALU decodes to INSTR_TYPE_MUL with out_illegal = 0.
- RV32M_DECODE_EN undefined:
  - that encoding sets out_illegal = 1 and out_instr_type = NO_WB
  - INSTR_TYPE_MUL is never produced

## Structure
- Shared package core_pkg holds:
  - OPCODE_*, MUL_FUNCT7, INSTR_TYPE_* and WORD_SIZE constants
  - a decoded-bundle struct typedef
  - pure functions for immediate generation and class/illegal decode
- Sub-module decode_queue: a generic DEPTH × (32+PC_W) FIFO. It provides push/pop, full/empty and count, and handles flush and asynchronous reset.
- decode_stage instantiates decode_queue and owns the output register and handshake.

## Test plan
- Decode check: push 0x002081B3 (add x3,x1,x2) → out_rs1=1, out_rs2=2, out_rd=3, out_instr_type=ALU, out_illegal=0. out_valid rises one edge after acceptance.
- M-extension: push 0x022081B3 (mul).
  - with RV32M_DECODE_EN → type MUL, out_illegal=0
  - without → out_illegal=1, type NO_WB
- Load immediate: push 0xFFC12283 (lw x5,-4(x2)) → out_imm=0xFFFFFFFC, out_rd=5, out_rs1=2, type LOAD.
- Backpressure (DEPTH=4, out_ready=0, in_valid held high):
  - exactly 5 instructions are accepted, then occupancy=4 and in_ready=0
  - raise out_ready → outputs arrive in push order at 1 per cycle
- Flush: with 3 queued entries and out_valid=1, pulse flush with in_valid=1 → next cycle out_valid=0, occupancy=0. The flushed-cycle input is never output.
- Illegal opcode and reset:
  - push 0x0000007F → out_illegal=1, type NO_WB
  - assert rst_n low mid-stream → all outputs 0 immediately; no stale entry is output after release

Source files
------------

// File: rtl/core_pkg.sv
// ============================================================================
// core_pkg : RV32 decode constants, bundle type and decode helper functions
// Optional macro: RV32M_DECODE_EN (M-extension decode)      Revision: 1.0
// ============================================================================
`default_nettype none

package core_pkg;

    localparam int WORD_SIZE = 32;

    localparam logic [6:0] OPCODE_LOAD    = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE   = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL     = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR    = 7'b1100111;
    localparam logic [6:0] OPCODE_ALU     = 7'b0110011;
    localparam logic [6:0] OPCODE_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPCODE_LUI     = 7'b0110111;
    localparam logic [6:0] OPCODE_NOP     = 7'b0001111;
    localparam logic [6:0] OPCODE_SYSTEM  = 7'b1110011;

    localparam logic [6:0] MUL_FUNCT7 = 7'b0000001;

    localparam logic [2:0] INSTR_TYPE_ALU   = 3'd0;
    localparam logic [2:0] INSTR_TYPE_LOAD  = 3'd1;
    localparam logic [2:0] INSTR_TYPE_STORE = 3'd2;
    localparam logic [2:0] INSTR_TYPE_MUL   = 3'd3;
    localparam logic [2:0] INSTR_TYPE_NO_WB = 3'd4;

`ifdef RV32M_DECODE_EN
    localparam bit c_m_decode_en = 1'b1;
`else
    localparam bit c_m_decode_en = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  funct7;
        logic [2:0]  funct3;
        logic [6:0]  opcode;
        logic [31:0] imm;
        logic [2:0]  instr_type;
        logic        illegal;
    } decoded_t;

    function automatic logic [31:0] gen_imm(input logic [31:0] instr);
        logic [31:0] imm;
        case (instr[6:0])
            OPCODE_LOAD, OPCODE_ALU_IMM:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPCODE_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPCODE_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPCODE_AUIPC, OPCODE_LUI:
                imm = {instr[31:12], 12'b0};
            default:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        endcase
        return imm;
    endfunction

    function automatic logic is_illegal(input logic [6:0] opcode, input logic [6:0] funct7);
        logic bad;
        bad = (opcode[1:0] != 2'b11);
        case (opcode)
            OPCODE_LOAD, OPCODE_STORE, OPCODE_BRANCH, OPCODE_JAL, OPCODE_JALR,
            OPCODE_ALU_IMM, OPCODE_AUIPC, OPCODE_LUI, OPCODE_NOP, OPCODE_SYSTEM:
                bad = bad;
            OPCODE_ALU:
                if (!(funct7 == 7'h00 || funct7 == 7'h20 ||
                      (c_m_decode_en && funct7 == MUL_FUNCT7)))
                    bad = 1'b1;
            default:
                bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [2:0] classify(input logic [6:0] opcode, input logic [6:0] funct7,
                                            input logic illegal);
        logic [2:0] t;
        case (opcode)
            OPCODE_ALU:                             t = (funct7 == MUL_FUNCT7) ? INSTR_TYPE_MUL
                                                                               : INSTR_TYPE_ALU;
            OPCODE_AUIPC, OPCODE_ALU_IMM, OPCODE_NOP: t = INSTR_TYPE_ALU;
            OPCODE_LOAD, OPCODE_LUI:                t = INSTR_TYPE_LOAD;
            OPCODE_STORE:                           t = INSTR_TYPE_STORE;
            default:                                t = INSTR_TYPE_NO_WB;
        endcase
        // Illegal words never write back, which also hides MUL when M decode is off
        if (illegal)
            t = INSTR_TYPE_NO_WB;
        return t;
    endfunction

    function automatic decoded_t decode(input logic [31:0] instr);
        decoded_t d;
        d.rs1        = instr[19:15];
        d.rs2        = instr[24:20];
        d.rd         = instr[11:7];
        d.funct7     = instr[31:25];
        d.funct3     = instr[14:12];
        d.opcode     = instr[6:0];
        d.imm        = gen_imm(instr);
        d.illegal    = is_illegal(instr[6:0], instr[31:25]);
        d.instr_type = classify(instr[6:0], instr[31:25], d.illegal);
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decode_queue.sv
// ============================================================================
// decode_queue : DEPTH-entry FIFO with synchronous flush, async active-low reset
// Revision: 1.0
// ============================================================================
`default_nettype none

module decode_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                  c_ptr_w    = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]    c_full_cnt = DEPTH[c_ptr_w:0];
    localparam logic [c_ptr_w:0]    c_cnt_one  = 1;
    localparam logic [c_ptr_w-1:0]  c_ptr_one  = 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign full      = (r_count == c_full_cnt);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rd_data   = r_mem[r_rd_ptr];
    assign w_push_ok = push && !full && !flush;
    assign w_pop_ok  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= wr_data;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop_ok)
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// decode_stage : buffered RV32 decode stage with registered valid/ready output
// Optional macro: RV32M_DECODE_EN (via core_pkg)            Revision: 1.0
// ============================================================================
`default_nettype none

module decode_stage
    import core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [PC_W-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        out_pc,
    output logic [4:0]             out_rs1,
    output logic [4:0]             out_rs2,
    output logic [4:0]             out_rd,
    output logic [6:0]             out_funct7,
    output logic [2:0]             out_funct3,
    output logic [6:0]             out_opcode,
    output logic [31:0]            out_imm,
    output logic [2:0]             out_instr_type,
    output logic                   out_illegal,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int c_width = WORD_SIZE + PC_W;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [c_width-1:0]   w_head;
    logic [WORD_SIZE-1:0] w_head_instr;
    logic [PC_W-1:0]      w_head_pc;
    decoded_t             w_dec;

    logic                 r_out_valid;
    logic [PC_W-1:0]      r_out_pc;
    decoded_t             r_out_dec;

    // in_ready depends only on queue state and flush, never on out_ready
    assign in_ready     = !w_full && !flush;
    assign w_push       = in_valid && in_ready;
    assign w_pop        = !w_empty && (!r_out_valid || out_ready) && !flush;
    assign w_head_instr = w_head[c_width-1:PC_W];
    assign w_head_pc    = w_head[PC_W-1:0];
    assign w_dec        = decode(w_head_instr);

    decode_queue #(
        .DEPTH (DEPTH),
        .WIDTH (c_width)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .push    (w_push),
        .pop     (w_pop),
        .wr_data ({in_instr, in_pc}),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (occupancy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_pc    <= '0;
            r_out_dec   <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_out_pc    <= w_head_pc;
            r_out_dec   <= w_dec;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid      = r_out_valid;
    assign out_pc         = r_out_pc;
    assign out_rs1        = r_out_dec.rs1;
    assign out_rs2        = r_out_dec.rs2;
    assign out_rd         = r_out_dec.rd;
    assign out_funct7     = r_out_dec.funct7;
    assign out_funct3     = r_out_dec.funct3;
    assign out_opcode     = r_out_dec.opcode;
    assign out_imm        = r_out_dec.imm;
    assign out_instr_type = r_out_dec.instr_type;
    assign out_illegal    = r_out_dec.illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// tb_decode_stage : randomized bench for decode_stage with a queue-based model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_decode_stage;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    localparam logic [2:0] T_ALU = 3'd0, T_LOAD = 3'd1, T_STORE = 3'd2, T_MUL = 3'd3, T_NOWB = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [6:0]  out_funct7;
    logic [2:0]  out_funct3;
    logic [6:0]  out_opcode;
    logic [31:0] out_imm;
    logic [2:0]  out_instr_type;
    logic        out_illegal;
    logic [2:0]  occupancy;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic [63:0] m_q [$];
    bit          m_valid = 1'b0;
    bit          m_zero = 1'b1;
    logic [31:0] m_instr = '0;
    logic [31:0] m_pc = '0;

    logic [6:0] legal_ops [0:10] = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h33,
                                     7'h13, 7'h17, 7'h37, 7'h0F, 7'h73};

    decode_stage #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_funct7(out_funct7), .out_funct3(out_funct3), .out_opcode(out_opcode),
        .out_imm(out_imm), .out_instr_type(out_instr_type), .out_illegal(out_illegal),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit op_known(input logic [6:0] op);
        foreach (legal_ops[i])
            if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_illegal(input logic [31:0] w);
        if (w[1:0] != 2'b11 || !op_known(w[6:0])) return 1'b1;
        if (w[6:0] == 7'h33) begin
            if (w[31:25] == 7'h00 || w[31:25] == 7'h20) return 1'b0;
`ifdef RV32M_DECODE_EN
            if (w[31:25] == 7'h01) return 1'b0;
`endif
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [2:0] exp_type(input logic [31:0] w);
        if (exp_illegal(w)) return T_NOWB;
        case (w[6:0])
            7'h33:               return (w[31:25] == 7'h01) ? T_MUL : T_ALU;
            7'h17, 7'h13, 7'h0F: return T_ALU;
            7'h03, 7'h37:        return T_LOAD;
            7'h23:               return T_STORE;
            default:             return T_NOWB;
        endcase
    endfunction

    function automatic logic [31:0] exp_imm(input logic [31:0] w);
        int v;
        case (w[6:0])
            7'h03, 7'h13: begin v = int'(w[31:20]); if (w[31]) v -= 4096; end
            7'h23:        begin v = int'({w[31:25], w[11:7]}); if (w[31]) v -= 4096; end
            7'h63:        begin v = int'({w[31], w[7], w[30:25], w[11:8], 1'b0}); if (w[31]) v -= 8192; end
            7'h17, 7'h37: v = int'(w & 32'hFFFFF000);
            default:      begin v = int'({w[31], w[19:12], w[20], w[30:21], 1'b0}); if (w[31]) v -= 2097152; end
        endcase
        return 32'(v);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        logic [6:0] f7s [0:3];
        w = $urandom();
        k = $urandom_range(0, 14);
        f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h01; f7s[3] = 7'($urandom());
        if (k < 11) begin
            w[6:0] = legal_ops[k];
            if (w[6:0] == 7'h33) w[31:25] = f7s[$urandom_range(0, 3)];
        end
        return w;
    endfunction

    // One clock edge of the reference: flush empties everything, otherwise
    // the output slot is refilled from the queue head before the new push.
    task automatic model_edge();
        bit push;
        logic [63:0] e;
        if (flush) begin
            m_q.delete();
            m_valid = 1'b0;
            return;
        end
        push = in_valid && (m_q.size() < DEPTH);
        if (m_q.size() > 0 && (!m_valid || out_ready)) begin
            e = m_q.pop_front();
            m_instr = e[63:32];
            m_pc = e[31:0];
            m_valid = 1'b1;
            m_zero = 1'b0;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        if (push) m_q.push_back({in_instr, in_pc});
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #2;
    endtask

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("in_ready", 32'(in_ready), 32'((m_q.size() < DEPTH) && !flush));
            check("occupancy", 32'(occupancy), 32'(m_q.size()));
            check("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_zero) begin
                check("zero_pc", out_pc, 32'h0);
                check("zero_fields", {out_rs1, out_rs2, out_rd, out_funct7, out_funct3, out_opcode}, 32'h0);
                check("zero_imm", out_imm, 32'h0);
                check("zero_type", {28'h0, out_instr_type, out_illegal}, 32'h0);
            end else begin
                check("out_pc", out_pc, m_pc);
                check("out_rs1", 32'(out_rs1), 32'(m_instr[19:15]));
                check("out_rs2", 32'(out_rs2), 32'(m_instr[24:20]));
                check("out_rd", 32'(out_rd), 32'(m_instr[11:7]));
                check("out_funct7", 32'(out_funct7), 32'(m_instr[31:25]));
                check("out_funct3", 32'(out_funct3), 32'(m_instr[14:12]));
                check("out_opcode", 32'(out_opcode), 32'(m_instr[6:0]));
                check("out_imm", out_imm, exp_imm(m_instr));
                check("out_type", 32'(out_instr_type), 32'(exp_type(m_instr)));
                check("out_illegal", 32'(out_illegal), 32'(exp_illegal(m_instr)));
            end
        end
    end

    task automatic push_and_see(input logic [31:0] w, input logic [31:0] pc);
        in_valid = 1'b1; in_instr = w; in_pc = pc; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("latency_not_yet", 32'(out_valid), 32'h0);
        step();
        @(negedge clk);
        check("latency_valid", 32'(out_valid), 32'h1);
        check("latency_pc", out_pc, pc);
    endtask

    initial begin
        int accepted;
        step(); step();
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'h1);
        check("reset_occupancy", 32'(occupancy), 32'h0);
        check("reset_out_valid", 32'(out_valid), 32'h0);

        push_and_see(32'h002081B3, 32'h1000);
        check("add_rs1", 32'(out_rs1), 32'd1);
        check("add_rs2", 32'(out_rs2), 32'd2);
        check("add_rd", 32'(out_rd), 32'd3);
        check("add_type", 32'(out_instr_type), 32'(T_ALU));
        check("add_illegal", 32'(out_illegal), 32'h0);

        push_and_see(32'h022081B3, 32'h1004);
`ifdef RV32M_DECODE_EN
        check("mul_type", 32'(out_instr_type), 32'(T_MUL));
        check("mul_illegal", 32'(out_illegal), 32'h0);
`else
        check("mul_type", 32'(out_instr_type), 32'(T_NOWB));
        check("mul_illegal", 32'(out_illegal), 32'h1);
`endif

        push_and_see(32'hFFC12283, 32'h1008);
        check("lw_imm", out_imm, 32'hFFFFFFFC);
        check("lw_rd", 32'(out_rd), 32'd5);
        check("lw_rs1", 32'(out_rs1), 32'd2);
        check("lw_type", 32'(out_instr_type), 32'(T_LOAD));

        push_and_see(32'h0000007F, 32'h100C);
        check("ill_flag", 32'(out_illegal), 32'h1);
        check("ill_type", 32'(out_instr_type), 32'(T_NOWB));
        step();

        // Backpressure: fill queue plus output register with out_ready low
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h200;
        in_instr = {7'h00, 5'd2, 5'd1, 3'd0, 5'd1, 7'h33};
        accepted = 0;
        for (int c = 0; c < 8; c++) begin
            bit acc;
            @(negedge clk);
            acc = in_ready;
            step();
            if (acc) begin
                accepted++;
                in_pc = in_pc + 32'd4;
                in_instr[11:7] = 5'(accepted + 1);
            end
        end
        in_valid = 1'b0;
        check("bp_accepted", 32'(accepted), 32'd5);
        @(negedge clk);
        check("bp_occupancy", 32'(occupancy), 32'd4);
        check("bp_in_ready", 32'(in_ready), 32'h0);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("bp_drain_valid", 32'(out_valid), 32'h1);
            check("bp_drain_pc", out_pc, 32'h200 + 32'(4 * k));
            step();
            @(negedge clk);
        end
        step();

        // Flush with three queued entries and a held output
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_pc = 32'h300 + 32'(4 * i);
            in_instr = rand_instr();
            step();
        end
        @(negedge clk);
        check("pre_flush_occ", 32'(occupancy), 32'd3);
        check("pre_flush_valid", 32'(out_valid), 32'h1);
        step();
        flush = 1'b1; in_pc = 32'hDEAD0;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", 32'(out_valid), 32'h0);
        check("flush_occ", 32'(occupancy), 32'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("flushed_out", 32'(out_valid), 32'h0);
            step();
        end

        // Asynchronous reset in the middle of traffic
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_pc = 32'h400 + 32'(4 * i);
            in_instr = rand_instr();
            step();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        m_q.delete(); m_valid = 1'b0; m_zero = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'h0);
        check("arst_occ", 32'(occupancy), 32'h0);
        check("arst_pc", out_pc, 32'h0);
        check("arst_imm", out_imm, 32'h0);
        check("arst_fields", {out_rs1, out_rs2, out_rd, out_instr_type, out_illegal}, 32'h0);
        step(); step();
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_in_ready", 32'(in_ready), 32'h1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("arst_no_stale", 32'(out_valid), 32'h0);
            step();
        end

        // Randomized traffic against the reference
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_instr  = rand_instr();
            in_pc     = $urandom();
            out_ready = ($urandom_range(0, 9) < (c < 750 ? 6 : 9));
            flush     = ($urandom_range(0, 39) == 0);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 8; c++) step();
        @(negedge clk);
        check("final_drained", 32'(out_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
